// File: rtl/lsu_align.sv
// lsu_align: issues aligned memory accesses, splitting misaligned loads into two word reads and misaligned stores into byte writes
module lsu_align (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rw,
   input  logic [2:0]  req_func,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_rw,
   output logic [2:0]  mem_func,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [2:0] {IDLE, LD_A, LD_B, LD_C, ST} state_t;
   state_t      state;
   logic [1:0]  off, cnt, last;
   logic        zx, wide, mis, err_pend, req_mis;
   logic [23:0] wd;
   logic [31:0] w0, dw, ld_res;
   assign req_ready = state == IDLE;
   assign req_mis = (req_func[1:0] == 2'b01 && req_addr[0]) ||
                    (req_func[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
   always_comb begin
      dw = 32'({mem_rdata, w0} >> {off, 3'b000});
      ld_res = wide ? dw : {{16{~zx & dw[15]}}, dw[15:0]};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_rw     <= 1'b0;
         mem_func   <= 3'b010;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         off        <= '0;
         cnt        <= '0;
         last       <= '0;
         zx         <= 1'b0;
         wide       <= 1'b0;
         mis        <= 1'b0;
         err_pend   <= 1'b0;
         wd         <= '0;
         w0         <= '0;
      end else begin
         // an illegal width never leaves IDLE; its response trails acceptance by one cycle
         resp_valid <= err_pend;
         err_pend   <= 1'b0;
         if (err_pend) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
         end
         case (state)
            IDLE: if (req_valid) begin
               off  <= req_addr[1:0];
               zx   <= req_func[2];
               wide <= req_func[1];
               mis  <= req_mis;
               if (&req_func[1:0]) err_pend <= 1'b1;
               else if (req_rw) begin
                  state     <= ST;
                  mem_rw    <= 1'b1;
                  cnt       <= '0;
                  last      <= req_mis ? (req_func[1] ? 2'd3 : 2'd1) : 2'd0;
                  mem_addr  <= req_addr;
                  mem_func  <= req_mis ? 3'b000 : req_func;
                  mem_wdata <= req_mis ? {24'h0, req_wdata[7:0]} : req_wdata;
                  wd        <= req_wdata[31:8];
               end else begin
                  state    <= LD_A;
                  mem_addr <= req_mis ? {req_addr[31:2], 2'b00} : req_addr;
                  mem_func <= req_mis ? 3'b010 : req_func;
               end
            end
            LD_A: begin
               if (mis) mem_addr <= mem_addr + 32'd4;
               state <= LD_B;
            end
            LD_B: begin
               w0 <= mem_rdata;
               if (mis) state <= LD_C;
               else begin
                  state      <= IDLE;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= mem_rdata;
               end
            end
            LD_C: begin
               state      <= IDLE;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= ld_res;
            end
            ST: if (cnt == last) begin
               state      <= IDLE;
               mem_rw     <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end else begin
               cnt       <= cnt + 2'd1;
               mem_addr  <= mem_addr + 32'd1;
               mem_wdata <= {24'h0, wd[7:0]};
               wd        <= wd >> 8;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit sitting directly upstream of the core's word-organised data memory. It accepts one load or store request at a time from the execute stage and issues aligned accesses to memory. Misaligned loads are split into two aligned word reads. Misaligned stores are split into byte writes. It returns one response per request: load data, store completion, or an error for an illegal width code.

## Interface
Parameters:
- none; address and data widths are fixed at 32 bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high exactly when state is IDLE
- req_rw  in  1  1 = store, 0 = load
- req_func  in  3  [1:0] width: 00 byte, 01 half, 10 word, 11 illegal; [2] = 1 zero-extend loads, 0 sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  single-cycle response pulse; no backpressure
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  out  1  high with resp_valid when req_func[1:0]==11
- mem_rw  out  1  registered; 1 = memory writes at next edge
- mem_func  out  3  registered width code to memory
- mem_addr  out  32  registered memory address
- mem_wdata  out  32  registered memory write data, right-justified
- mem_rdata  in  32  memory read data; valid the cycle after the edge at which memory sampled mem_addr with mem_rw=0

## Operation
- States:
  - IDLE: accepts requests.
  - LD_A, LD_B, LD_C: three cycles of an aligned or split load.
  - ST: counts through byte stores.
- Accept: at an edge with req_valid && state==IDLE, latch the request.
- Width 11 (illegal), load or store:
  - No memory access is made; mem_rw stays 0.
  - Next cycle: resp_valid=1, resp_err=1; state stays IDLE.
- Misalignment:
  - A half access is misaligned when addr[0]==1.
  - A word access is misaligned when addr[1:0]!=0.
  - Byte accesses are never misaligned.
- Aligned load:
  - mem_addr=addr, mem_func=func, mem_rw=0.
  - resp_rdata=mem_rdata, taken unchanged (memory performs the extension).
- Misaligned load:
  - Issue a word read of addr&~3, then a word read of (addr&~3)+4, with mem_func=010. The +4 wraps modulo 2^32.
  - Form the 64-bit value {w1,w0}, shift right by 8*addr[1:0], and keep 16 or 32 bits.
  - Extend per func[2].
- Aligned store:
  - One cycle with mem_rw=1, mem_addr=addr, mem_func=func, mem_wdata=wdata.
- Misaligned store:
  - N byte writes (N=2 for half, 4 for word). Write i uses mem_addr=addr+i (wrapping), mem_func=000, and mem_wdata=wdata[8i+7:8i].
  - A counter counts i from 0 to N-1.
- mem_rw is 1 only during store write cycles. At all other times mem_rw=0, and the memory performs a harmless read.
- Reset mid-operation:
  - The operation is aborted and no response is produced.
  - A partially completed split store leaves the bytes already written in place.
- Reset values:
  - state=IDLE (so req_ready=1 during and after reset)
  - resp_valid=0, resp_err=0, resp_rdata=0
  - mem_rw=0, mem_func=010, mem_addr=0, mem_wdata=0

## Timing
- Notation: E0 is the acceptance edge; resp_valid is high during the cycle following edge Ek.
- Illegal width: response after E1.
- Aligned store: memory writes at E1; response after E1.
- Split store: memory writes at E1..EN; response after EN; mem_rw drops at EN.
- Aligned load:
  - Memory samples at E1.
  - The unit captures mem_rdata at E2; response after E2.
- Misaligned load:
  - Memory samples word0 at E1 and word1 at E2.
  - The unit captures w0 at E2 and w1 at E3; response after E3.
- The response cycle is in IDLE, so req_ready=1 alongside resp_valid. A new request accepted there starts back-to-back with no bubble.
- Requests presented while not IDLE are ignored; the requester holds them until req_ready is high.
- resp_rdata and resp_err hold their values until the next response.

## Test plan
- Preload mem 0x100=0x44332211 and 0x104=0x88776655.
  - Aligned LW 0x100 -> resp_rdata=0x44332211, resp_valid 2 cycles after acceptance, mem_rw never 1.
- Misaligned LW 0x102 -> reads 0x100 then 0x104 -> 0x66554433 after 3 cycles.
- LH 0x103 -> 0x00005544.
- LB 0x107 -> 0xFFFFFF88.
- LBU (func 100) 0x107 -> 0x00000088.
- SW 0xAABBCCDD at 0x101:
  - Four byte writes at 0x101..0x104.
  - mem becomes 0x100=0xBBCCDD11 and 0x104=0x887766AA.
  - resp_valid 4 cycles after acceptance, resp_rdata=0.
- func 011, load and store -> resp_err=1 one cycle after acceptance, mem_rw stays 0.
- Two back-to-back requests:
  - Second accepted in first's response cycle -> both respond, no lost request.
- Reset mid-operation:
  - Assert rst after the 2nd byte of a split SW -> all outputs at reset values immediately, only 2 bytes changed.
  - After reset, req_ready=1.
- LW 0xFFFFFFFE -> second read at mem_addr 0x00000000 (wrap); result assembled correctly.
